sram_drain: RTL

SRAM_DRAIN -- requirements
Module: sram_drain

---
 rtl/sram_drain_pkg.sv | 15 +
 rtl/sram_drain.sv | 112 +++++++++++
 2 files changed

// File: rtl/sram_drain_pkg.sv
// Shared definitions for the bank II drain engine: default widths and FSM state encoding.
package sram_drain_pkg;

  localparam int unsigned SRAM_ADDR_LEN = 15;
  localparam int unsigned REG_WORD_LEN  = 16;

  // Readout sequencer states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/sram_drain.sv
// Streams a block of words out of data bank II (combinational-read SRAM) onto a
// valid/ready interface.
//   clk, rst (sync, active-low)
//   start, base_addr, count  : request, sampled in IDLE only
//   read_addr / read_data    : bank II read port
//   out_data/out_valid/out_last/out_ready : registered output stream
//   busy, done               : transfer status, done pulses once per transfer
module sram_drain
  import sram_drain_pkg::*;
#(
  parameter int unsigned ADDR_W = SRAM_ADDR_LEN,
  parameter int unsigned DATA_W = REG_WORD_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  drain_state_t state, state_d;

  logic [ADDR_W-1:0] addr, addr_d;
  logic [ADDR_W:0]   remaining, remaining_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d, out_last_d, busy_d, done_d;
  logic              accept;

  assign accept    = out_valid && out_ready;
  assign read_addr = addr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (start) state_d = (count != '0) ? ST_FETCH : ST_DONE;
      ST_FETCH: state_d = ST_SEND;
      ST_SEND:  if (accept && out_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output register next values; a word is loaded in FETCH and on
  // every non-final accept so the stream runs at one word per cycle.
  always_comb begin
    addr_d      = addr;
    remaining_d = remaining;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    case (state)
      ST_IDLE: begin
        if (start && (count != '0)) begin
          addr_d      = base_addr;
          remaining_d = count;
        end
      end
      ST_FETCH, ST_SEND: begin
        if ((state == ST_FETCH) || (accept && !out_last)) begin
          out_data_d  = read_data;
          out_valid_d = 1'b1;
          out_last_d  = (remaining == (ADDR_W+1)'(1));
          addr_d      = addr + ADDR_W'(1);
          remaining_d = remaining - (ADDR_W+1)'(1);
        end else if (accept) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_SEND);
    done_d = (state_d == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      addr      <= addr_d;
      remaining <= remaining_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
